// File: rtl/drum_sample_scheduler.sv
// drum_sample_scheduler
//   Sequences a bank of drum-mesh column engines. After reset or a strike the
//   columns are held in reset for RESET_CYCLES, then the scheduler waits for
//   all of them to report done. Each sample tick launches one mesh iteration.
//   When every column is done again, the centre node is scaled by GAIN_SHIFT,
//   saturated and handed to the audio FIFO over a valid/ready handshake.
//
//   Optional build macro INTERNAL_TICK_EN: sample ticks come from an internal
//   0..TICK_DIV-1 divider and the sample_tick port is ignored.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   sample_tick       one-cycle pulse per audio sample
//   strike            one-cycle pulse, reinitialise the mesh
//   col_done          per-column iteration-done flags
//   center_node       signed 1.17 centre node value
//   col_reset         reset to all columns
//   iteration_enable  one-cycle start pulse to all columns
//   sample_valid/sample_ready/sample_data  audio sample handshake
//   busy              low only in READY
//   overrun_count     saturating count of dropped ticks
//   iter_cycles       cycle count of the last completed iteration
//   timeout_err       sticky iteration timeout flag
module drum_sample_scheduler #(
  parameter int NUM_COLS     = 30,
  parameter int RESET_CYCLES = 4,
  parameter int MAX_CYCLES   = 4095,
  parameter int GAIN_SHIFT   = 2,
  parameter int TICK_DIV     = 1042
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_tick,
  input  logic                       strike,
  input  logic [NUM_COLS-1:0]        col_done,
  input  logic signed [17:0]         center_node,
  output logic                       col_reset,
  output logic                       iteration_enable,
  output logic                       sample_valid,
  input  logic                       sample_ready,
  output logic [15:0]                sample_data,
  output logic                       busy,
  output logic [15:0]                overrun_count,
  output logic [12:0]                iter_cycles,
  output logic                       timeout_err
);

  localparam int HW = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(RESET_CYCLES - 1);
  localparam logic [12:0]   MAXC      = 13'(MAX_CYCLES);
  localparam int SW = 18 + GAIN_SHIFT;
  localparam logic signed [SW-1:0] SAT_HI = SW'(131071);
  localparam logic signed [SW-1:0] SAT_LO = SW'(-131072);

  typedef enum logic [2:0] {HOLD, LOADWAIT, READY, ARM, RUN, PUSH} state_t;

  state_t      state;
  logic [HW-1:0] hold_cnt;
  logic [12:0] cyc_cnt;
  logic        tick;
  logic        all_done;

  assign all_done = &col_done;

`ifdef INTERNAL_TICK_EN
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] DIV_LAST = TW'(TICK_DIV - 1);
  logic [TW-1:0] div_cnt;

  // Free-running divider; strike deliberately does not touch it so the
  // audio rate stays locked.
  always_ff @(posedge clk) begin
    if (reset)                  div_cnt <= '0;
    else if (div_cnt == DIV_LAST) div_cnt <= '0;
    else                        div_cnt <= div_cnt + 1'b1;
  end
  assign tick = (div_cnt == DIV_LAST);
`else
  assign tick = sample_tick;
`endif

  // Gain and saturation: widen so the shift cannot wrap, then clamp to the
  // 18-bit range and keep the top 16 bits.
  logic signed [SW-1:0] ext, shifted;
  logic [17:0] sat;

  assign ext     = SW'(center_node);
  assign shifted = ext <<< GAIN_SHIFT;

  always_comb begin
    sat = shifted[17:0];
    if (shifted > SAT_HI)      sat = 18'h1FFFF;
    else if (shifted < SAT_LO) sat = 18'h20000;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= HOLD;
      hold_cnt         <= '0;
      cyc_cnt          <= '0;
      col_reset        <= 1'b1;
      iteration_enable <= 1'b0;
      sample_valid     <= 1'b0;
      sample_data      <= '0;
      overrun_count    <= '0;
      iter_cycles      <= '0;
      timeout_err      <= 1'b0;
      busy             <= 1'b1;
    end else begin
      iteration_enable <= 1'b0;

      // A tick is only consumed in READY without a strike; anything else is
      // dropped and counted.
      if (tick && (strike || state != READY) && overrun_count != 16'hFFFF)
        overrun_count <= overrun_count + 16'd1;

      if (strike) begin
        state        <= HOLD;
        hold_cnt     <= '0;
        col_reset    <= 1'b1;
        sample_valid <= 1'b0;
        busy         <= 1'b1;
      end else begin
        case (state)
          HOLD: begin
            if (hold_cnt == HOLD_LAST) begin
              col_reset <= 1'b0;
              state     <= LOADWAIT;
            end else begin
              hold_cnt <= hold_cnt + 1'b1;
            end
          end
          LOADWAIT: begin
            if (all_done) begin
              state <= READY;
              busy  <= 1'b0;
            end
          end
          READY: begin
            if (tick) begin
              iteration_enable <= 1'b1;
              cyc_cnt          <= 13'd1;
              state            <= ARM;
              busy             <= 1'b1;
            end
          end
          // Columns still show done from the previous iteration here.
          ARM: begin
            cyc_cnt <= cyc_cnt + 13'd1;
            state   <= RUN;
          end
          RUN: begin
            if (all_done) begin
              iter_cycles  <= cyc_cnt;
              sample_data  <= sat[17:2];
              sample_valid <= 1'b1;
              state        <= PUSH;
            end else if (cyc_cnt >= MAXC) begin
              timeout_err <= 1'b1;
              state       <= HOLD;
              hold_cnt    <= '0;
              col_reset   <= 1'b1;
            end else begin
              cyc_cnt <= cyc_cnt + 13'd1;
            end
          end
          PUSH: begin
            if (sample_ready) begin
              sample_valid <= 1'b0;
              state        <= READY;
              busy         <= 1'b0;
            end
          end
          default: begin
            state     <= HOLD;
            hold_cnt  <= '0;
            col_reset <= 1'b1;
            busy      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_drum_sample_scheduler.sv
// Directed bench for drum_sample_scheduler (NUM_COLS=4, MAX_CYCLES=100).
// The stimulus process pushes expected samples; the monitor pops and
// compares them on every handshake and checks data stability while stalled.
module tb_drum_sample_scheduler;

  logic               clk = 1'b0;
  logic               reset;
  logic               sample_tick;
  logic               strike;
  logic [3:0]         col_done;
  logic signed [17:0] center_node;
  logic               col_reset;
  logic               iteration_enable;
  logic               sample_valid;
  logic               sample_ready;
  logic [15:0]        sample_data;
  logic               busy;
  logic [15:0]        overrun_count;
  logic [12:0]        iter_cycles;
  logic               timeout_err;

  drum_sample_scheduler #(
    .NUM_COLS(4), .RESET_CYCLES(4), .MAX_CYCLES(100), .GAIN_SHIFT(2), .TICK_DIV(1042)
  ) dut (
    .clk(clk), .reset(reset), .sample_tick(sample_tick), .strike(strike),
    .col_done(col_done), .center_node(center_node), .col_reset(col_reset),
    .iteration_enable(iteration_enable), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_data(sample_data), .busy(busy),
    .overrun_count(overrun_count), .iter_cycles(iter_cycles),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] data;
    logic [12:0] iter;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   en_count = 0;
  int   hs_count = 0;
  int   exp_ovr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: scoreboard pop on handshake, hold-stability while stalled.
  initial begin
    logic        pv, pr;
    logic [15:0] pd;
    exp_t        e;
    pv = 1'b0; pr = 1'b0; pd = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (iteration_enable) en_count++;
        if (sample_valid) begin
          if (pv && !pr) chk("hold_stable", {16'd0, sample_data}, {16'd0, pd});
          if (sample_ready) begin
            hs_count++;
            if (sb.size() == 0) begin
              chk("unexpected_sample", 32'd1, 32'd0);
            end else begin
              e = sb.pop_front();
              chk("sample_data", {16'd0, sample_data}, {16'd0, e.data});
              chk("iter_cycles", {19'd0, iter_cycles}, {19'd0, e.iter});
            end
          end
        end
        pv = sample_valid;
        pr = sample_ready;
        pd = sample_data;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // One iteration: tick, columns busy for lat cycles starting one cycle after
  // the enable, optional tick during RUN and ticks during PUSH, then accept.
  task automatic do_iter(input logic [17:0] c, input int lat, input logic [15:0] ed,
                         input logic [12:0] ei, input bit rt, input int pt);
    int   e0, h0;
    bit   got;
    exp_t e;
    e0 = en_count;
    h0 = hs_count;
    e.data = ed;
    e.iter = ei;
    sb.push_back(e);
    center_node = c;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    col_done = 4'h0;
    for (int i = 0; i < lat; i++) begin
      if (rt && i == 0) sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
    end
    col_done = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = sample_valid;
    end
    chk("valid_seen", {31'd0, got}, 32'd1);
    for (int k = 0; k < pt; k++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      step();
    end
    repeat (2) step();
    sample_ready = 1'b1;
    step();
    sample_ready = 1'b0;
    exp_ovr += (rt ? 1 : 0) + pt;
    chk("enable_pulses", en_count - e0, 32'd1);
    chk("handshakes", hs_count - h0, 32'd1);
    chk("overrun_count", {16'd0, overrun_count}, exp_ovr);
    chk("valid_after_hs", {31'd0, sample_valid}, 32'd0);
    chk("busy_ready", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int  cr;
    bit  got;
    int  h0;
    reset = 1'b1; sample_tick = 1'b0; strike = 1'b0; col_done = 4'h0;
    sample_ready = 1'b0; center_node = '0;
    repeat (3) step();

    chk("rst_col_reset", {31'd0, col_reset}, 32'd1);
    chk("rst_iter_en", {31'd0, iteration_enable}, 32'd0);
    chk("rst_valid", {31'd0, sample_valid}, 32'd0);
    chk("rst_data", {16'd0, sample_data}, 32'd0);
    chk("rst_overrun", {16'd0, overrun_count}, 32'd0);
    chk("rst_iter_cycles", {19'd0, iter_cycles}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);

    // Reset release: 4-cycle column reset, LOADWAIT tick counted as overrun.
    reset = 1'b0;
    cr = col_reset ? 1 : 0;
    for (int i = 1; i <= 12; i++) begin
      sample_tick = (i == 7);
      step();
      sample_tick = 1'b0;
      if (col_reset) cr++;
      if (i == 8) chk("busy_loadwait", {31'd0, busy}, 32'd1);
      if (i == 10) col_done = 4'hF;
    end
    exp_ovr = 1;
    chk("col_reset_cycles", cr, 32'd4);
    chk("busy_after_load", {31'd0, busy}, 32'd0);
    chk("no_enable_at_load", en_count, 32'd0);
    chk("overrun_loadwait", {16'd0, overrun_count}, exp_ovr);

    do_iter(18'h02000, 20, 16'h2000, 13'd22, 1'b0, 0);
    do_iter(18'h1FFFF,  5, 16'h7FFF, 13'd7,  1'b0, 0);
    do_iter(18'h20000,  3, 16'h8000, 13'd5,  1'b0, 0);
    do_iter(18'h08000, 10, 16'h7FFF, 13'd12, 1'b0, 0);
    do_iter(18'h3F000,  2, 16'hF000, 13'd4,  1'b0, 0);
    do_iter(18'h3FFFF,  1, 16'hFFFF, 13'd3,  1'b0, 0);
    do_iter(18'h00004, 10, 16'h0004, 13'd12, 1'b1, 3);

    // Timeout: columns never finish.
    h0 = hs_count;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    col_done = 4'h0;
    repeat (98) step();
    chk("timeout_before", {31'd0, timeout_err}, 32'd0);
    chk("col_reset_before", {31'd0, col_reset}, 32'd0);
    step();
    chk("timeout_at_max", {31'd0, timeout_err}, 32'd1);
    chk("col_reset_timeout", {31'd0, col_reset}, 32'd1);
    chk("busy_timeout", {31'd0, busy}, 32'd1);
    col_done = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      step();
      got = !busy;
    end
    chk("recover_ready", {31'd0, got}, 32'd1);
    chk("timeout_sticky", {31'd0, timeout_err}, 32'd1);
    chk("no_sample_timeout", hs_count - h0, 32'd0);
    do_iter(18'h01000, 4, 16'h1000, 13'd6, 1'b0, 0);
    chk("timeout_sticky2", {31'd0, timeout_err}, 32'd1);

    // Strike during PUSH, coincident with a tick.
    h0 = hs_count;
    center_node = 18'h00100;
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    step();
    col_done = 4'h0;
    repeat (5) step();
    col_done = 4'hF;
    got = 1'b0;
    for (int i = 0; i < 5 && !got; i++) begin
      step();
      got = sample_valid;
    end
    chk("strike_valid_seen", {31'd0, got}, 32'd1);
    strike = 1'b1;
    sample_tick = 1'b1;
    step();
    strike = 1'b0;
    sample_tick = 1'b0;
    exp_ovr++;
    chk("strike_valid_drop", {31'd0, sample_valid}, 32'd0);
    chk("strike_col_reset", {31'd0, col_reset}, 32'd1);
    chk("strike_busy", {31'd0, busy}, 32'd1);
    chk("strike_overrun", {16'd0, overrun_count}, exp_ovr);
    cr = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      if (col_reset) cr++;
      if (i == 4) chk("strike_loadwait", {31'd0, busy}, 32'd1);
      if (i == 5) chk("strike_ready", {31'd0, busy}, 32'd0);
    end
    chk("strike_hold_cycles", cr, 32'd4);
    chk("strike_no_hs", hs_count - h0, 32'd0);

    do_iter(18'h00400, 2, 16'h0400, 13'd4, 1'b0, 0);
    chk("sb_drained", sb.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
